// File: rtl/plic_ctx_agent_pkg.sv
// plic_ctx_agent_pkg
//   Shared definitions for the PLIC context agent: PLIC register map
//   constants (30-bit register offsets) and the agent state encoding.
package plic_ctx_agent_pkg;

  localparam logic [29:0] PRIO_BASE = 30'h0000_0000;
  localparam logic [29:0] ENBL_BASE = 30'h0000_2000;
  localparam logic [29:0] ENBL_SIZE = 30'h0000_0080;
  localparam logic [29:0] THRS_BASE = 30'h0020_0000;
  localparam logic [29:0] CLAM_BASE = 30'h0020_0004;
  localparam logic [29:0] CLAM_SIZE = 30'h0000_1000;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_CFG_PRIO = 4'd1,
    S_CFG_EN   = 4'd2,
    S_CFG_THR  = 4'd3,
    S_WAIT     = 4'd4,
    S_CLAIM    = 4'd5,
    S_CAPT     = 4'd6,
    S_OFFER    = 4'd7,
    S_BUSY     = 4'd8,
    S_COMPLETE = 4'd9,
    S_HOLD     = 4'd10
  } agent_state_e;

endpackage

// File: rtl/plic_ctx_agent.sv
// plic_ctx_agent
//   Hardware interrupt-service agent for one PLIC context. Acts as the bus
//   initiator on the PLIC register port: programs priorities, enable word
//   and threshold, then claims, offers and completes interrupts on behalf
//   of a fixed-function consumer.
//
// Ports
//   CLK, RST_X            clock, async active-low reset
//   o_offset/o_we/o_wdata PLIC register write port (one cycle per write)
//   o_re, i_rdata         PLIC read strobe; data valid the following cycle
//   i_eip                 external-interrupt-pending for context CTX
//   i_cfg_start           starts configuration (honoured in IDLE/WAIT)
//   i_cfg_en, i_cfg_thr   enable mask (bit k = ID k+1) and threshold
//   o_cfg_done            high once configuration has completed
//   o_irq_valid/o_irq_id  claimed ID offered to the consumer
//   i_irq_ready           consumer accepts the ID
//   i_irq_done            consumer finished servicing (pulse)
//   o_err                 sticky: a claim returned an ID > N_INT_SRC
//
// State table
//   state      | meaning
//   S_IDLE     | unconfigured, waiting for i_cfg_start
//   S_CFG_PRIO | writing one priority per cycle, IDs 1..N_INT_SRC
//   S_CFG_EN   | writing the context enable word
//   S_CFG_THR  | writing the context threshold
//   S_WAIT     | configured, watching i_eip
//   S_CLAIM    | one-cycle read of the claim register
//   S_CAPT     | PLIC read data arrives; classify the ID
//   S_OFFER    | o_irq_valid high until i_irq_ready
//   S_BUSY     | consumer servicing, waiting for i_irq_done
//   S_COMPLETE | one-cycle completion write of the ID
//   S_HOLD     | two cycles letting the PLIC's registered eip settle
module plic_ctx_agent
  import plic_ctx_agent_pkg::*;
#(
  parameter int N_INT_SRC = 31,
  parameter int CTX       = 0,
  parameter int W_INT_ID  = 5
) (
  input  logic                 CLK,
  input  logic                 RST_X,
  output logic [29:0]          o_offset,
  output logic                 o_we,
  output logic [31:0]          o_wdata,
  output logic                 o_re,
  input  logic [31:0]          i_rdata,
  input  logic                 i_eip,
  input  logic                 i_cfg_start,
  input  logic [N_INT_SRC-1:0] i_cfg_en,
  input  logic [2:0]           i_cfg_thr,
  output logic                 o_cfg_done,
  output logic                 o_irq_valid,
  output logic [W_INT_ID-1:0]  o_irq_id,
  input  logic                 i_irq_ready,
  input  logic                 i_irq_done,
  output logic                 o_err
);

  // Threshold and claim registers share the same 4 KiB per-context stride.
  localparam logic [29:0] ENBL_ADDR = ENBL_BASE + ENBL_SIZE * 30'(CTX);
  localparam logic [29:0] THRS_ADDR = THRS_BASE + CLAM_SIZE * 30'(CTX);
  localparam logic [29:0] CLAM_ADDR = CLAM_BASE + CLAM_SIZE * 30'(CTX);
  localparam logic [4:0]  SRC_LAST  = 5'(N_INT_SRC);

  agent_state_e          state_q, state_d;
  logic [4:0]            src_q, src_d;
  logic [W_INT_ID-1:0]   id_q, id_d;
  logic                  hold_q, hold_d;
  logic                  err_q, err_d;
  logic                  done_q, done_d;

  logic [29:0]           offset_q, offset_d;
  logic                  we_q, we_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  re_q, re_d;
  logic                  valid_q, valid_d;

  logic [31:0]           en_ext;

  assign en_ext = 32'(i_cfg_en);

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    id_d    = id_q;
    hold_d  = hold_q;
    err_d   = err_q;
    done_d  = done_q;
    case (state_q)
      S_IDLE: begin
        if (i_cfg_start) begin
          state_d = S_CFG_PRIO;
          src_d   = 5'd1;
        end
      end
      S_CFG_PRIO: begin
        if (src_q == SRC_LAST) state_d = S_CFG_EN;
        else                   src_d   = src_q + 5'd1;
      end
      S_CFG_EN:  state_d = S_CFG_THR;
      S_CFG_THR: begin
        state_d = S_WAIT;
        done_d  = 1'b1;
      end
      S_WAIT: begin
        // A pending interrupt wins over a simultaneous reconfiguration request.
        if (i_eip) begin
          state_d = S_CLAIM;
        end else if (i_cfg_start) begin
          state_d = S_CFG_PRIO;
          src_d   = 5'd1;
          done_d  = 1'b0;
        end
      end
      S_CLAIM: state_d = S_CAPT;
      S_CAPT: begin
        if (i_rdata == 32'd0) begin
          state_d = S_HOLD;
          hold_d  = 1'b1;
        end else if (i_rdata > 32'(N_INT_SRC)) begin
          err_d   = 1'b1;
          state_d = S_HOLD;
          hold_d  = 1'b1;
        end else begin
          id_d    = i_rdata[W_INT_ID-1:0];
          state_d = S_OFFER;
        end
      end
      S_OFFER: begin
        if (i_irq_ready) state_d = i_irq_done ? S_COMPLETE : S_BUSY;
      end
      S_BUSY: begin
        if (i_irq_done) state_d = S_COMPLETE;
      end
      S_COMPLETE: begin
        state_d = S_HOLD;
        hold_d  = 1'b1;
      end
      S_HOLD: begin
        if (hold_q == 1'b0) state_d = S_WAIT;
        else                hold_d  = hold_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus outputs are decoded from the state being entered so that they are
  // registered and line up with that state's cycle.
  always_comb begin
    offset_d = '0;
    we_d     = 1'b0;
    wdata_d  = '0;
    re_d     = 1'b0;
    case (state_d)
      S_CFG_PRIO: begin
        we_d     = 1'b1;
        offset_d = PRIO_BASE + {23'd0, src_d, 2'b00};
        wdata_d  = {31'd0, en_ext[src_d - 5'd1]};
      end
      S_CFG_EN: begin
        we_d     = 1'b1;
        offset_d = ENBL_ADDR;
        wdata_d  = 32'({i_cfg_en, 1'b0});
      end
      S_CFG_THR: begin
        we_d     = 1'b1;
        offset_d = THRS_ADDR;
        wdata_d  = {29'd0, i_cfg_thr};
      end
      S_CLAIM: begin
        re_d     = 1'b1;
        offset_d = CLAM_ADDR;
      end
      S_COMPLETE: begin
        we_d     = 1'b1;
        offset_d = CLAM_ADDR;
        wdata_d  = 32'(id_d);
      end
      default: ;
    endcase
    valid_d = (state_d == S_OFFER);
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state_q  <= S_IDLE;
      src_q    <= '0;
      id_q     <= '0;
      hold_q   <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      offset_q <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      re_q     <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      id_q     <= id_d;
      hold_q   <= hold_d;
      err_q    <= err_d;
      done_q   <= done_d;
      offset_q <= offset_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      re_q     <= re_d;
      valid_q  <= valid_d;
    end
  end

  assign o_offset    = offset_q;
  assign o_we        = we_q;
  assign o_wdata     = wdata_q;
  assign o_re        = re_q;
  assign o_cfg_done  = done_q;
  assign o_irq_valid = valid_q;
  assign o_irq_id    = id_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_plic_ctx_agent.sv
// tb_plic_ctx_agent
//   Bench for plic_ctx_agent with three sources on context 0. A small PLIC
//   model (gateways, priorities, enable, threshold, claim/complete,
//   registered eip) answers the agent; directed steps plus randomized
//   rounds compare logged bus traffic and offered IDs with expectations.
module tb_plic_ctx_agent;

  localparam int NS = 3;
  localparam logic [29:0] ENBL_A = 30'h0000_2000;
  localparam logic [29:0] THRS_A = 30'h0020_0000;
  localparam logic [29:0] CLAM_A = 30'h0020_0004;

  typedef struct {
    int          c;
    logic [29:0] off;
    logic [31:0] d;
  } bus_t;

  logic          CLK;
  logic          RST_X;
  logic [29:0]   o_offset;
  logic          o_we;
  logic [31:0]   o_wdata;
  logic          o_re;
  logic [31:0]   m_rdata;
  logic          m_eip;
  logic          cfg_start;
  logic [NS-1:0] cfg_en;
  logic [2:0]    cfg_thr;
  logic          o_cfg_done;
  logic          o_irq_valid;
  logic [4:0]    o_irq_id;
  logic          irq_ready;
  logic          irq_done;
  logic          o_err;

  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  bus_t wlog[$];
  bus_t rlog[$];
  int   vlog[$];

  bit          src    [0:NS];
  bit          m_pend [0:NS];
  bit          m_infl [0:NS];
  logic [2:0]  m_prio [0:NS];
  logic [31:0] m_en_w;
  logic [2:0]  m_thr;
  logic        force_on;
  logic [31:0] force_val;
  logic        m_clr;

  plic_ctx_agent #(.N_INT_SRC(NS), .CTX(0), .W_INT_ID(5)) dut (
    .CLK(CLK), .RST_X(RST_X),
    .o_offset(o_offset), .o_we(o_we), .o_wdata(o_wdata), .o_re(o_re),
    .i_rdata(m_rdata), .i_eip(m_eip),
    .i_cfg_start(cfg_start), .i_cfg_en(cfg_en), .i_cfg_thr(cfg_thr),
    .o_cfg_done(o_cfg_done), .o_irq_valid(o_irq_valid), .o_irq_id(o_irq_id),
    .i_irq_ready(irq_ready), .i_irq_done(irq_done), .o_err(o_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // PLIC model: lowest eligible ID wins (all priorities are 0 or 1).
  always @(posedge CLK or negedge RST_X) begin
    bit p [0:NS];
    bit f [0:NS];
    int best;
    bit e;
    if (!RST_X) begin
      for (int k = 0; k <= NS; k++) begin
        m_pend[k] <= 1'b0;
        m_infl[k] <= 1'b0;
        m_prio[k] <= 3'd0;
      end
      m_en_w  <= '0;
      m_thr   <= '0;
      m_eip   <= 1'b0;
      m_rdata <= '0;
    end else begin
      p = m_pend;
      f = m_infl;
      best = 0;
      if (m_clr) for (int k = 0; k <= NS; k++) p[k] = 1'b0;
      if (o_we) begin
        if (o_offset == CLAM_A) begin
          for (int k = 1; k <= NS; k++) if (o_wdata == 32'(k)) f[k] = 1'b0;
        end else if (o_offset == ENBL_A) begin
          m_en_w <= o_wdata;
        end else if (o_offset == THRS_A) begin
          m_thr <= o_wdata[2:0];
        end else begin
          for (int k = 1; k <= NS; k++) if (o_offset == 30'(4 * k)) m_prio[k] <= o_wdata[2:0];
        end
      end
      if (o_re && o_offset == CLAM_A) begin
        if (force_on) begin
          m_rdata <= force_val;
          for (int k = 0; k <= NS; k++) p[k] = 1'b0;
        end else begin
          for (int k = NS; k >= 1; k--)
            if (p[k] && ((m_en_w >> k) & 32'd1) != 0 && m_prio[k] > m_thr) best = k;
          m_rdata <= 32'(best);
          if (best != 0) begin
            p[best] = 1'b0;
            f[best] = 1'b1;
          end
        end
      end
      for (int k = 1; k <= NS; k++) if (src[k] && !f[k]) p[k] = 1'b1;
      e = 1'b0;
      for (int k = 1; k <= NS; k++)
        if (p[k] && ((m_en_w >> k) & 32'd1) != 0 && m_prio[k] > m_thr) e = 1'b1;
      m_pend <= p;
      m_infl <= f;
      m_eip  <= e;
    end
  end

  // Bus monitor plus per-cycle strobe invariants.
  always @(negedge CLK) begin
    if (RST_X) begin
      if (o_we) wlog.push_back('{cyc, o_offset, o_wdata});
      if (o_re) rlog.push_back('{cyc, o_offset, 32'd0});
      if (o_irq_valid) vlog.push_back(int'(o_irq_id));
      tests += 3;
      assert ((o_we & o_re) === 1'b0)
        else begin fails++; $error("FAIL strobe_excl: observed we=%0b re=%0b expected not both", o_we, o_re); end
      assert (((o_we | o_re) ? 30'd0 : o_offset) === 30'd0)
        else begin fails++; $error("FAIL idle_offset: observed 0x%0h expected 0x0", o_offset); end
      assert ((o_we ? 32'd0 : o_wdata) === 32'd0)
        else begin fails++; $error("FAIL idle_wdata: observed 0x%0h expected 0x0", o_wdata); end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
      else begin fails++; $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp); end
  endtask

  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_offset"}, 32'(o_offset), 32'd0);
    chk({tag, "_we"}, 32'(o_we), 32'd0);
    chk({tag, "_wdata"}, o_wdata, 32'd0);
    chk({tag, "_re"}, 32'(o_re), 32'd0);
    chk({tag, "_cfg_done"}, 32'(o_cfg_done), 32'd0);
    chk({tag, "_valid"}, 32'(o_irq_valid), 32'd0);
    chk({tag, "_id"}, 32'(o_irq_id), 32'd0);
    chk({tag, "_err"}, 32'(o_err), 32'd0);
  endtask

  task automatic do_config(input logic [NS-1:0] m, input logic [2:0] t);
    int c0;
    logic [29:0] eo;
    logic [31:0] ed;
    wlog.delete();
    cfg_en = m;
    cfg_thr = t;
    cfg_start = 1'b1;
    c0 = cyc;
    step();
    cfg_start = 1'b0;
    chk("cfg_done_clr", 32'(o_cfg_done), 32'd0);
    repeat (NS + 1) step();
    chk("cfg_thr_we", 32'(o_we), 32'd1);
    chk("cfg_done_early", 32'(o_cfg_done), 32'd0);
    step();
    chk("cfg_done", 32'(o_cfg_done), 32'd1);
    chk("cfg_nwrites", 32'(wlog.size()), 32'(NS + 2));
    for (int i = 0; i < NS + 2; i++) begin
      if (i < NS) begin
        eo = 30'(4 * (i + 1));
        ed = 32'((m >> i) & 1);
      end else if (i == NS) begin
        eo = ENBL_A;
        ed = 32'({m, 1'b0});
      end else begin
        eo = THRS_A;
        ed = 32'(t);
      end
      if (i < wlog.size()) begin
        chk("cfg_off", 32'(wlog[i].off), 32'(eo));
        chk("cfg_data", wlog[i].d, ed);
        chk("cfg_cycle", 32'(wlog[i].c), 32'(c0 + 1 + i));
      end
    end
  endtask

  task automatic serve(input int id, input int rdly, input int ddly);
    int n;
    int dc;
    wlog.delete();
    n = 0;
    while (!o_irq_valid && n < 40) begin
      step();
      n++;
    end
    chk("valid_up", 32'(o_irq_valid), 32'd1);
    chk("irq_id", 32'(o_irq_id), 32'(id));
    repeat (rdly) step();
    chk("valid_hold", 32'(o_irq_valid), 32'd1);
    irq_ready = 1'b1;
    if (ddly == 0) begin
      irq_done = 1'b1;
      src[id] = 1'b0;
    end
    dc = cyc;
    step();
    irq_ready = 1'b0;
    irq_done = 1'b0;
    chk("valid_drop", 32'(o_irq_valid), 32'd0);
    if (ddly != 0) begin
      repeat (ddly - 1) step();
      chk("no_early_cpl", 32'(wlog.size()), 32'd0);
      irq_done = 1'b1;
      src[id] = 1'b0;
      dc = cyc;
      step();
      irq_done = 1'b0;
    end
    chk("cpl_count", 32'(wlog.size()), 32'd1);
    if (wlog.size() == 1) begin
      chk("cpl_off", 32'(wlog[0].off), 32'(CLAM_A));
      chk("cpl_data", wlog[0].d, 32'(id));
      chk("cpl_cycle", 32'(wlog[0].c), 32'(dc + 1));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [NS-1:0] rm;
    logic [2:0] rt;
    int rs;
    int expq[$];

    RST_X = 1'b0;
    cfg_start = 1'b0;
    cfg_en = '0;
    cfg_thr = '0;
    irq_ready = 1'b0;
    irq_done = 1'b0;
    force_on = 1'b0;
    force_val = '0;
    m_clr = 1'b0;
    for (int k = 0; k <= NS; k++) src[k] = 1'b0;
    repeat (3) step();
    chk_zero("rst");
    RST_X = 1'b1;
    step();

    // Directed configuration: mask 101, threshold 0.
    do_config(3'b101, 3'd0);

    // Single source 3: claim timing, then ready/done.
    rlog.delete();
    src[3] = 1'b1;
    n = 0;
    while (!m_eip && n < 20) begin
      step();
      n++;
    end
    chk("eip_rise", 32'(m_eip), 32'd1);
    step();
    chk("claim_re", 32'(o_re), 32'd1);
    chk("claim_off", 32'(o_offset), 32'(CLAM_A));
    step();
    chk("claim_re_1cyc", 32'(o_re), 32'd0);
    chk("capt_valid_lo", 32'(o_irq_valid), 32'd0);
    step();
    chk("offer_valid", 32'(o_irq_valid), 32'd1);
    chk("offer_id", 32'(o_irq_id), 32'd3);
    serve(3, 2, 2);
    chk("claim_reads_1", 32'(rlog.size()), 32'd1);

    // Sources 1 and 3 together: 1 first, 3 after; second uses ready+done together.
    repeat (4) step();
    rlog.delete();
    src[1] = 1'b1;
    src[3] = 1'b1;
    serve(1, 0, 1);
    serve(3, 1, 0);
    repeat (6) step();
    chk("claim_reads_2", 32'(rlog.size()), 32'd2);

    // Spurious claim (ID 0): no offer, no completion.
    wlog.delete(); rlog.delete(); vlog.delete();
    force_on = 1'b1;
    force_val = 32'd0;
    src[1] = 1'b1;
    n = 0;
    while (!o_re && n < 20) begin
      step();
      n++;
    end
    chk("spur_re", 32'(o_re), 32'd1);
    src[1] = 1'b0;
    repeat (12) step();
    chk("spur_reads", 32'(rlog.size()), 32'd1);
    chk("spur_no_valid", 32'(vlog.size()), 32'd0);
    chk("spur_no_cpl", 32'(wlog.size()), 32'd0);
    chk("spur_no_err", 32'(o_err), 32'd0);

    // Out-of-range claim (ID 40): error flag, no offer, no completion.
    wlog.delete(); rlog.delete(); vlog.delete();
    force_val = 32'd40;
    src[1] = 1'b1;
    n = 0;
    while (!o_re && n < 20) begin
      step();
      n++;
    end
    chk("bad_re", 32'(o_re), 32'd1);
    src[1] = 1'b0;
    repeat (12) step();
    force_on = 1'b0;
    chk("bad_err", 32'(o_err), 32'd1);
    chk("bad_no_valid", 32'(vlog.size()), 32'd0);
    chk("bad_no_cpl", 32'(wlog.size()), 32'd0);
    src[3] = 1'b1;
    serve(3, 0, 0);
    chk("err_sticky", 32'(o_err), 32'd1);

    // Reset while the consumer is busy.
    repeat (4) step();
    src[1] = 1'b1;
    n = 0;
    while (!o_irq_valid && n < 40) begin
      step();
      n++;
    end
    chk("busy_valid", 32'(o_irq_valid), 32'd1);
    irq_ready = 1'b1;
    step();
    irq_ready = 1'b0;
    #2;
    RST_X = 1'b0;
    #1;
    chk_zero("rst_busy");
    src[1] = 1'b0;
    step();
    step();
    wlog.delete(); rlog.delete();
    RST_X = 1'b1;
    repeat (10) step();
    chk("post_rst_writes", 32'(wlog.size()), 32'd0);
    chk("post_rst_reads", 32'(rlog.size()), 32'd0);

    // Randomized rounds: reconfigure, raise a random subset, serve in ID order.
    for (int r = 0; r < 8; r++) begin
      rm = NS'($urandom_range(1, 7));
      rt = ($urandom_range(0, 3) == 0) ? 3'd1 : 3'd0;
      do_config(rm, rt);
      rs = int'($urandom_range(1, 7));
      expq.delete();
      for (int k = 1; k <= NS; k++)
        if (rt == 3'd0 && ((rs >> (k - 1)) & 1) != 0 && ((rm >> (k - 1)) & 1) != 0) expq.push_back(k);
      rlog.delete(); vlog.delete();
      for (int k = 1; k <= NS; k++) src[k] = ((rs >> (k - 1)) & 1) != 0;
      foreach (expq[i]) serve(expq[i], int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      repeat (10) step();
      chk("rnd_claims", 32'(rlog.size()), 32'(expq.size()));
      if (expq.size() == 0) chk("rnd_no_valid", 32'(vlog.size()), 32'd0);
      for (int k = 1; k <= NS; k++) src[k] = 1'b0;
      m_clr = 1'b1;
      step();
      m_clr = 1'b0;
      repeat (2) step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/plic_ctx_agent.md
# plic_ctx_agent

Hardware interrupt-service agent for one PLIC context, acting as the bus initiator on the PLIC register port in place of a hart. After a start pulse it programs per-source priorities, the context enable word and the threshold. It then watches the context's external-interrupt line, claims the winning ID, hands the ID to a hardware consumer over a valid/ready/done handshake, and writes the completion. It sits between the PLIC and fixed-function logic (e.g. a DMA or a console engine) that must service interrupts without firmware.

## Interface
Parameters:
- `N_INT_SRC`, default 31: number of sources; legal range 1..31 (single enable word, IDs 1..N_INT_SRC).
- `CTX`, default 0: PLIC context index served.
- `W_INT_ID`, default 5: width of the ID output; must satisfy 2^W_INT_ID > N_INT_SRC.

Ports:
- `CLK`  in  1  clock.
- `RST_X`  in  1  reset; asynchronous, active-low.
- `o_offset`  out  30  PLIC register offset.
- `o_we`  out  1  write strobe, one cycle per write.
- `o_wdata`  out  32  write data.
- `o_re`  out  1  read strobe; for the claim register this is the claim side effect.
- `i_rdata`  in  32  PLIC read data, registered inside the PLIC: valid the cycle after `o_offset`/`o_re`.
- `i_eip`  in  1  external-interrupt-pending output of the PLIC for context `CTX`.
- `i_cfg_start`  in  1  pulse that starts the configuration sequence.
- `i_cfg_en`  in  N_INT_SRC  source enable mask; bit k corresponds to ID k+1.
- `i_cfg_thr`  in  3  context threshold.
- `o_cfg_done`  out  1  level signal, high once configuration has completed.
- `o_irq_valid`  out  1  claimed ID is being offered to the consumer.
- `o_irq_id`  out  W_INT_ID  the claimed ID.
- `i_irq_ready`  in  1  consumer accepts the offered ID.
- `i_irq_done`  in  1  consumer has finished servicing; pulse.
- `o_err`  out  1  sticky flag: a claim returned an ID greater than N_INT_SRC.

## Operation
- Address map used:
  - priority: `4*id`
  - enable: `0x2000+0x80*CTX`
  - threshold: `0x200000+0x1000*CTX`
  - claim/complete: `0x200004+0x1000*CTX`
- States:
  - `IDLE` → `CFG_PRIO` on `i_cfg_start`.
  - `CFG_PRIO`: writes priority 1 to IDs 1..N_INT_SRC whose enable bit is set and priority 0 to the rest; one write per cycle in ascending ID order. → `CFG_EN`.
  - `CFG_EN`: writes `{i_cfg_en, 1'b0}` zero-extended to 32 bits. → `CFG_THR`.
  - `CFG_THR`: writes `i_cfg_thr`; sets `o_cfg_done`. → `WAIT`.
  - `WAIT`: on `i_eip` → `CLAIM`. On `i_cfg_start` → `CFG_PRIO`, with `o_cfg_done` cleared.
  - `CLAIM`: `o_offset`=claim address, `o_re`=1 for exactly one cycle. → `CAPT`.
  - `CAPT`: samples `i_rdata`.
    - ID 0: spurious; → `HOLD`, no completion.
    - ID > N_INT_SRC: sets `o_err`; → `HOLD`, no completion.
    - Otherwise: latches the ID; → `OFFER`.
  - `OFFER`: `o_irq_valid`=1 until `i_irq_ready` is sampled high. → `BUSY`.
  - `BUSY`: wait for `i_irq_done`. A done that arrives in the same cycle as the ready is honoured, and the agent goes straight to `COMPLETE`.
  - `COMPLETE`: `o_we`=1, offset=claim address, `o_wdata`=ID, one cycle. → `HOLD`.
  - `HOLD`: 2 cycles, which covers the PLIC's registered `eip`. → `WAIT`.
- `i_cfg_start` is ignored outside `IDLE`/`WAIT`.
- `i_cfg_en` and `i_cfg_thr` are sampled on each write cycle. They must be held stable during configuration.
- `o_we` and `o_re` are never high together.
- `o_offset` is 0 whenever both strobes are low.
- `o_wdata` is 0 when `o_we` is low.

## Timing
- Reset values: state `IDLE`; `o_offset`, `o_wdata`, `o_irq_id` all 0; `o_we`, `o_re`, `o_cfg_done`, `o_irq_valid`, `o_err` all 0.
- All outputs are registered.
- Configuration:
  - First write occurs the cycle after `i_cfg_start` is sampled.
  - Total of N_INT_SRC+2 write cycles.
  - `o_cfg_done` rises the cycle after the threshold write.
- Claim path:
  - `i_eip` sampled high in `WAIT` at edge t: `o_re` is high in cycle t+1, `i_rdata` is sampled at edge t+2, `o_irq_valid` is high from cycle t+3.
- Completion: the write cycle immediately follows the edge at which `i_irq_done` was sampled.
- Minimum claim-to-reclaim spacing: completion + 2 `HOLD` cycles + 1.
- Reset is asynchronous: asserting it mid-sequence, including during an outstanding claim, returns everything to reset values at once. No completion is issued; the PLIC is reset together with the agent.

## Structure
- A shared package holds:
  - PLIC address constants: `PRIO_BASE`, `ENBL_BASE`, `ENBL_SIZE`, `THRS_BASE`, `CLAM_BASE`, `CLAM_SIZE`.
  - The state encoding.
- One FSM plus a source counter (ID 1..N_INT_SRC), an ID register and a `HOLD` counter.
- No sub-module.

## Test plan
- Reset, then `i_cfg_start` with N=3, `i_cfg_en`=3'b101, `i_cfg_thr`=0 → writes in order: (0x4,1), (0x8,0), (0xC,1), (0x2000,0xA), (0x200000,0); then `o_cfg_done`=1.
- Source 3 raised → one claim read at 0x200004 → `o_irq_id`=3 with `o_irq_valid`; ready, then done → one write (0x200004,3); then `HOLD`.
- Sources 1 and 3 raised together → ID 1 is served first, ID 3 after the completion of ID 1.
- A PLIC model returns 0 on the claim → no `o_irq_valid`, no completion write, back to `WAIT`. Returning 40 instead → `o_err`=1.
- `i_irq_ready` and `i_irq_done` high in the same cycle → completion issued next cycle; `o_irq_valid` drops.
- `RST_X` asserted in `BUSY` → all outputs 0 immediately; no completion write after release.
